// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame receiver.
// Holds the sync byte, error codes, FSM state enums and the baud divider helper.
package uart_frame_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    CSUM    = 2'd0,
    FRAMING = 2'd1,
    LEN     = 2'd2,
    TIMEOUT = 2'd3
  } err_code_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  typedef enum logic [2:0] {
    P_SYNC,
    P_CMD,
    P_LEN,
    P_PAY,
    P_CSUM
  } parse_state_t;

  // Clocks per 16x oversampling tick, never below one.
  function automatic int div_of(int clk_freq, int baud);
    int d;
    d = clk_freq / (baud * 16);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 byte receiver: rx synchroniser, 16x baud tick and bit-level FSM.
// Ports: clk, rst_n, rx in; byte_data, byte_valid, framing_err, tick, idle out.
module uart_rx_core
  import uart_frame_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       framing_err,
  output logic       tick,
  output logic       idle
);

  localparam int DIV = div_of(CLK_FREQ, BAUD);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          s1;
  logic          s2;
  rx_state_t     st;
  logic [3:0]    tcnt;
  logic [2:0]    bitn;
  logic [7:0]    shift;

  assign tick = (div_cnt == DW'(DIV - 1));
  assign idle = (st == RX_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= rx;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= RX_IDLE;
      tcnt        <= '0;
      bitn        <= '0;
      shift       <= '0;
      byte_data   <= '0;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
      unique case (st)
        RX_IDLE: begin
          if (!s2) begin
            tcnt <= '0;
            st   <= RX_START;
          end
        end
        RX_START: begin
          if (tick) begin
            if (tcnt == 4'd7) begin
              tcnt <= '0;
              bitn <= '0;
              // A high line at mid-bit was only a glitch.
              st   <= s2 ? RX_IDLE : RX_DATA;
            end else begin
              tcnt <= tcnt + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            tcnt <= tcnt + 4'd1;
            if (tcnt == 4'd15) begin
              shift <= {s2, shift[7:1]};
              bitn  <= bitn + 3'd1;
              if (bitn == 3'd7) st <= RX_STOP;
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            tcnt <= tcnt + 4'd1;
            if (tcnt == 4'd15) begin
              if (s2) begin
                byte_data  <= shift;
                byte_valid <= 1'b1;
                st         <= RX_IDLE;
              end else begin
                framing_err <= 1'b1;
                st          <= RX_BREAK;
              end
            end
          end
        end
        RX_BREAK: begin
          if (s2) st <= RX_IDLE;
        end
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_receiver.sv
// Frame parser on top of uart_rx_core: A5, CMD, LEN, payload, XOR checksum.
// Ports: CLOCK_50, RESET_N, uart_rx in; byte, payload, frame status, busy out.
module uart_frame_receiver
  import uart_frame_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int MAX_LEN      = 16,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       uart_rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic [7:0] cmd,
  output logic [7:0] pay_data,
  output logic       pay_valid,
  output logic       pay_last,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int GAP_MAX = TIMEOUT_BITS * 16;
  localparam int GW      = $clog2(GAP_MAX + 1);

  logic         ferr;
  logic         tick;
  logic         rx_idle;
  parse_state_t ps;
  logic [7:0]   csum;
  logic [7:0]   len;
  logic [7:0]   cnt;
  logic [GW-1:0] gap;
  logic         counting;
  logic         timeout;

  uart_rx_core #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_core (
    .clk        (CLOCK_50),
    .rst_n      (RESET_N),
    .rx         (uart_rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .framing_err(ferr),
    .tick       (tick),
    .idle       (rx_idle)
  );

  assign busy     = (ps != P_SYNC);
  // Gap only grows while the line is quiet inside a frame.
  assign counting = busy && rx_idle && tick;
  assign timeout  = counting && (gap == GW'(GAP_MAX - 1));

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      ps         <= P_SYNC;
      csum       <= '0;
      len        <= '0;
      cnt        <= '0;
      gap        <= '0;
      cmd        <= '0;
      pay_data   <= '0;
      pay_valid  <= 1'b0;
      pay_last   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= '0;
    end else begin
      pay_valid  <= 1'b0;
      pay_last   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (ferr && busy) begin
        frame_err <= 1'b1;
        err_code  <= FRAMING;
        ps        <= P_SYNC;
        gap       <= '0;
      end else if (byte_valid) begin
        gap <= '0;
        unique case (ps)
          P_SYNC: begin
            if (byte_data == SYNC_BYTE) ps <= P_CMD;
          end
          P_CMD: begin
            cmd  <= byte_data;
            csum <= byte_data;
            ps   <= P_LEN;
          end
          P_LEN: begin
            csum <= csum ^ byte_data;
            len  <= byte_data;
            cnt  <= '0;
            if (byte_data > 8'(MAX_LEN)) begin
              frame_err <= 1'b1;
              err_code  <= LEN;
              ps        <= P_SYNC;
            end else if (byte_data == 8'd0) begin
              ps <= P_CSUM;
            end else begin
              ps <= P_PAY;
            end
          end
          P_PAY: begin
            csum      <= csum ^ byte_data;
            pay_data  <= byte_data;
            pay_valid <= 1'b1;
            cnt       <= cnt + 8'd1;
            if (cnt == len - 8'd1) begin
              pay_last <= 1'b1;
              ps       <= P_CSUM;
            end
          end
          P_CSUM: begin
            if (byte_data == csum) begin
              frame_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_code  <= CSUM;
            end
            ps <= P_SYNC;
          end
          default: ps <= P_SYNC;
        endcase
      end else if (timeout) begin
        frame_err <= 1'b1;
        err_code  <= TIMEOUT;
        ps        <= P_SYNC;
        gap       <= '0;
      end else if (!busy) begin
        gap <= '0;
      end else if (counting) begin
        gap <= gap + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Directed bench for uart_frame_receiver at 16 clocks per bit.
// Table of whole frames plus hand sequences for glitch, framing, timeout, reset.
module tb_uart_frame_receiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic [7:0] cmd;
  logic [7:0] pay_data;
  logic       pay_valid;
  logic       pay_last;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  always #5 clk = ~clk;

  uart_frame_receiver #(
    .CLK_FREQ    (1_600_000),
    .BAUD        (100_000),
    .MAX_LEN     (16),
    .TIMEOUT_BITS(40)
  ) dut (
    .CLOCK_50  (clk),
    .RESET_N   (rst_n),
    .uart_rx   (rx),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .cmd       (cmd),
    .pay_data  (pay_data),
    .pay_valid (pay_valid),
    .pay_last  (pay_last),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  typedef struct {
    logic [0:5][7:0] b;
    int              n;
    logic [7:0]      cmd;
    int              npay;
    logic [7:0]      p0;
    logic [7:0]      p1;
    int              done;
    int              err;
    int              code;
    int              lat;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_bv, n_last, n_done, n_err, n_both;
  int bv_cyc, err_cyc;
  int last_code;
  logic [7:0] last_pay;
  logic [7:0] pays[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid) begin
        n_bv++;
        bv_cyc = cyc;
      end
      if (pay_valid) pays.push_back(pay_data);
      if (pay_valid && pay_last) begin
        n_last++;
        last_pay = pay_data;
      end
      if (frame_done) n_done++;
      if (frame_err) begin
        n_err++;
        err_cyc = cyc;
        last_code = int'(err_code);
      end
      if (frame_done && frame_err) n_both++;
    end
  end

  task automatic clr();
    n_bv = 0; n_last = 0; n_done = 0;
    n_err = 0; n_both = 0;
    bv_cyc = 0; err_cyc = 0;
    last_code = -1; last_pay = 8'h00;
    pays.delete();
  endtask

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                  nm, act, act, exp, exp);
  endtask

  task automatic bit_t(logic v);
    rx = v;
    repeat (16) @(negedge clk);
  endtask

  task automatic send(logic [7:0] b, logic stop = 1'b1);
    bit_t(1'b0);
    for (int i = 0; i < 8; i++) bit_t(b[i]);
    bit_t(stop);
    rx = 1'b1;
  endtask

  function automatic vec_t mk(logic [0:5][7:0] b, int n,
                              logic [7:0] c, int np,
                              logic [7:0] p0, logic [7:0] p1,
                              int dn, int er, int cd, int lt);
    vec_t v;
    v.b = b; v.n = n; v.cmd = c; v.npay = np;
    v.p0 = p0; v.p1 = p1; v.done = dn; v.err = er;
    v.code = cd; v.lat = lt;
    return v;
  endfunction

  vec_t vecs[5];

  initial begin
    vecs[0] = mk({8'hA5, 8'h01, 8'h02, 8'h3C, 8'h7E, 8'h41},
                 6, 8'h01, 2, 8'h3C, 8'h7E, 1, 0, -1, 0);
    vecs[1] = mk({8'hA5, 8'h10, 8'h00, 8'hFF, 8'h00, 8'h00},
                 4, 8'h10, 0, 8'h00, 8'h00, 0, 1, 0, 1);
    vecs[2] = mk({8'hA5, 8'h02, 8'h11, 8'h00, 8'h00, 8'h00},
                 3, 8'h02, 0, 8'h00, 8'h00, 0, 1, 2, 1);
    vecs[3] = mk({8'hA5, 8'h03, 8'h00, 8'h03, 8'h00, 8'h00},
                 4, 8'h03, 0, 8'h00, 8'h00, 1, 0, -1, 0);
    vecs[4] = mk({8'h00, 8'hA5, 8'h04, 8'h01, 8'h99, 8'h9C},
                 6, 8'h04, 1, 8'h99, 8'h00, 1, 0, -1, 0);

    clr();
    repeat (5) @(negedge clk);
    chk("reset_outs", int'({byte_data, byte_valid, cmd, pay_data,
        pay_valid, pay_last, frame_done, frame_err, err_code}), 0);
    chk("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      clr();
      for (int i = 0; i < vecs[v].n; i++) send(vecs[v].b[i]);
      repeat (40) @(negedge clk);
      chk($sformatf("v%0d_bytes", v), n_bv, vecs[v].n);
      chk($sformatf("v%0d_cmd", v), int'(cmd), int'(vecs[v].cmd));
      chk($sformatf("v%0d_npay", v), pays.size(), vecs[v].npay);
      if (vecs[v].npay > 0)
        chk($sformatf("v%0d_pay0", v), int'(pays[0]), int'(vecs[v].p0));
      if (vecs[v].npay > 1)
        chk($sformatf("v%0d_pay1", v), int'(pays[1]), int'(vecs[v].p1));
      chk($sformatf("v%0d_nlast", v), n_last,
          (vecs[v].npay > 0) ? 1 : 0);
      if (vecs[v].npay > 0)
        chk($sformatf("v%0d_lastpay", v), int'(last_pay),
            int'((vecs[v].npay > 1) ? vecs[v].p1 : vecs[v].p0));
      chk($sformatf("v%0d_done", v), n_done, vecs[v].done);
      chk($sformatf("v%0d_err", v), n_err, vecs[v].err);
      if (vecs[v].err > 0)
        chk($sformatf("v%0d_code", v), last_code, vecs[v].code);
      if (vecs[v].lat > 0)
        chk($sformatf("v%0d_lat", v), err_cyc - bv_cyc, vecs[v].lat);
      chk($sformatf("v%0d_busy", v), int'(busy), 0);
      chk($sformatf("v%0d_both", v), n_both, 0);
    end

    // Short low glitch on an idle line.
    clr();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_bytes", n_bv, 0);
    chk("glitch_busy", int'(busy), 0);

    // Bad stop bit inside a frame.
    clr();
    send(8'hA5);
    send(8'h05);
    send(8'h55, 1'b0);
    repeat (40) @(negedge clk);
    chk("fram_bytes", n_bv, 2);
    chk("fram_err", n_err, 1);
    chk("fram_code", last_code, 1);
    chk("fram_busy", int'(busy), 0);

    // Bad stop bit while hunting for sync stays silent.
    clr();
    send(8'h33, 1'b0);
    repeat (40) @(negedge clk);
    chk("fsync_err", n_err, 0);
    chk("fsync_bytes", n_bv, 0);

    // Stall inside the payload.
    clr();
    send(8'hA5);
    send(8'h07);
    send(8'h03);
    send(8'hAA);
    repeat (41 * 16) @(negedge clk);
    chk("to_err", n_err, 1);
    chk("to_code", last_code, 3);
    chk("to_lat", err_cyc - bv_cyc, 641);
    chk("to_npay", pays.size(), 1);
    chk("to_done", n_done, 0);
    chk("to_busy", int'(busy), 0);

    // Reset in the middle of payload bit 3.
    clr();
    send(8'hA5);
    send(8'h01);
    send(8'h02);
    bit_t(1'b0);
    for (int i = 0; i < 3; i++) bit_t(logic'((8'h3C >> i) & 8'h01));
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_outs", int'({byte_data, byte_valid, cmd, pay_data,
        pay_valid, pay_last, frame_done, frame_err, err_code}), 0);
    chk("rst_busy", int'(busy), 0);
    repeat (4) @(negedge clk);
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    clr();
    send(8'hA5);
    send(8'h01);
    send(8'h02);
    send(8'h3C);
    send(8'h7E);
    send(8'h41);
    repeat (40) @(negedge clk);
    chk("post_done", n_done, 1);
    chk("post_err", n_err, 0);
    chk("post_cmd", int'(cmd), 1);
    chk("post_npay", pays.size(), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_frame_receiver.md
Name: uart_frame_receiver

Overview:
- Receive-side counterpart of the board's UART sender.
- Deserialises an 8N1 serial line into bytes, then parses them into command frames.
- Frame format: 0xA5 sync, CMD, LEN, LEN payload bytes, XOR checksum.
- Sits between the GPIO RX pin and the door-monitor control logic. Delivers the command byte, streams the payload, and flags errors.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- MAX_LEN, 16: maximum accepted payload length in bytes (1..255).
- TIMEOUT_BITS, 40: maximum inter-byte gap inside a frame, in bit-times.

Ports:
- CLOCK_50 in 1: system clock, rising edge.
- RESET_N in 1: asynchronous active-low reset.
- uart_rx in 1: raw serial input; idle level is high.
- byte_data out 8: last received raw byte.
- byte_valid out 1: one-cycle pulse per good byte.
- cmd out 8: CMD field of the current frame.
- pay_data out 8: payload byte.
- pay_valid out 1: one-cycle payload strobe. There is no backpressure.
- pay_last out 1: asserted with the final payload byte.
- frame_done out 1: one-cycle pulse when the checksum matches.
- frame_err out 1: one-cycle pulse when a frame is aborted.
- err_code out 2: error cause, valid with frame_err. 0 = checksum, 1 = framing, 2 = length, 3 = timeout.
- busy out 1: high while the parser is outside SYNC.

Behaviour:
- Reset values:
  - All outputs are 0.
  - Internal rx synchroniser flops reset to 1.
  - Both FSMs reset to idle/SYNC.
  - Reset mid-byte or mid-frame discards all state immediately.
- Baud tick:
  - Tick every DIV = CLK_FREQ/(BAUD*16) cycles (integer division, minimum 1). This gives 16x oversampling.
  - The divider counter free-runs; it is reset only by RESET_N.
- Input sync: 2-FF synchroniser on uart_rx. All logic uses the synchronised value.
- Receiver FSM:
  - RX_IDLE: a synchronised low starts a start bit. Clear the tick count and go to RX_START.
  - RX_START: at tick 7 (mid-bit), if the line is low go to RX_DATA. If it is high, treat it as a glitch and return to RX_IDLE with no error.
  - RX_DATA: sample every 16 ticks, LSB first, 8 bits.
  - RX_STOP: sample 16 ticks after the last data bit.
    - High: latch byte_data and pulse byte_valid.
    - Low: framing error. No byte_valid; go to RX_BREAK.
  - RX_BREAK: wait for the line to be high, then go to RX_IDLE.
  - Latency: byte_valid asserts 1 cycle after the stop-bit sample.
- Parser FSM (advances only on byte_valid):
  - P_SYNC: 0xA5 goes to P_CMD. Any other byte is dropped silently.
  - P_CMD: latch cmd, csum = byte, go to P_LEN.
  - P_LEN:
    - LEN > MAX_LEN: frame_err with code 2, back to P_SYNC.
    - LEN = 0: go to P_CSUM.
    - Otherwise: go to P_PAY.
    - In all cases csum ^= LEN.
  - P_PAY: pay_data = byte and pay_valid pulses in the same cycle as byte_valid+1. csum ^= byte. pay_last is high on byte LEN. After the last byte go to P_CSUM.
  - P_CSUM:
    - byte == csum: frame_done.
    - Otherwise: frame_err with code 0.
    - Either way, go to P_SYNC.
- Framing error with the parser outside P_SYNC: frame_err with code 1, parser goes to P_SYNC. In P_SYNC a framing error is silent.
- Timeout:
  - The gap counter counts baud ticks while the parser is not in P_SYNC and the receiver is in RX_IDLE.
  - It clears on every byte_valid.
  - When it reaches TIMEOUT_BITS*16: frame_err with code 3, go to P_SYNC.
- Simultaneous events: a framing error and a timeout in the same cycle report framing (code 1).
- Pulse exclusivity: frame_done and frame_err never assert together.
- Payload on abort: payload already emitted is not retracted. Consumers must discard it on frame_err.
- cmd holds its value until the next P_CMD byte.

Decomposition:
- Package uart_frame_pkg holds:
  - SYNC_BYTE = 8'hA5
  - err_code_t enum: CSUM, FRAMING, LEN, TIMEOUT
  - rx_state_t and parse_state_t enums
- One sub-module: uart_rx_core. It contains the synchroniser, baud tick and receiver FSM, and outputs byte_data, byte_valid and framing_err. The parser stays in the top level.

Test Plan:
- Bench settings: CLK_FREQ=1_600_000, BAUD=100_000, so DIV=1 and 16 cycles per bit.
- Good frame: send A5,01,02,3C,7E,45 (checksum 01^02^3C^7E = 0x41, so send 41 instead of 45 here). Expect cmd=01, pay_valid twice with 3C then 7E, pay_last on 7E, frame_done once, frame_err never.
- Bad checksum: send A5,10,00,FF. Expect frame_err with err_code=0, no frame_done, busy low afterwards.
- Oversized length: send A5,02,11 with MAX_LEN=16. Expect frame_err with err_code=2 immediately after the LEN byte. A following A5,03,00,03 yields frame_done.
- Glitch and framing:
  - A 4-cycle low pulse on an idle line produces no byte_valid.
  - A byte sent with stop bit 0 after A5,05 gives frame_err with err_code=1.
- Timeout: send A5,07,03,AA, then hold the line high for 41 bit-times. Expect frame_err with err_code=3 after exactly 640 ticks with no byte activity.
- Reset mid-frame: pull RESET_N low during the payload bit 3. All outputs read 0, busy=0, and the next complete good frame is accepted.
